// File: rtl/rprelu_ctrl_pkg.sv
// ============================================================================
// Module   : rprelu_ctrl_pkg
// Brief    : Shared FSM state, drain latency and mode encodings for the RPReLU
//            parameter controller. Build macro: RPRELU_PARAM_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PARA_WIDTH
`define PARA_WIDTH 16
`endif

`ifndef CALCULATE
`define CALCULATE 1'b1
`endif

package rprelu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_BETA  = 3'd1,
        ST_LOAD_GAMMA = 3'd2,
        ST_LOAD_ZETA  = 3'd3,
        ST_LOAD_CHK   = 3'd4,
        ST_RUN        = 3'd5,
        ST_DRAIN      = 3'd6
    } ctrl_state_e;

    localparam int   C_DRAIN_LAT      = 3;
    localparam int   C_DRAIN_CNT_W    = 2;
    localparam logic C_MODE_CALCULATE = `CALCULATE;
    localparam logic C_MODE_CONFIG    = ~(`CALCULATE);

endpackage

`default_nettype wire

// File: rtl/rprelu_param_bank.sv
// ============================================================================
// Module   : rprelu_param_bank
// Brief    : One RPReLU parameter bank; single write port, whole array visible.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rprelu_param_bank #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 16,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        idx_i,
    input  logic signed [WIDTH-1:0] wdata_i,
    output logic signed [WIDTH-1:0] mem_o [DEPTH]
);

    logic signed [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign mem_o = mem_q;

endmodule

`default_nettype wire

// File: rtl/rprelu_param_ctrl.sv
// ============================================================================
// Module   : rprelu_param_ctrl
// Brief    : Loads beta/gamma/zeta banks from a valid/ready stream, then gates
//            the datapath enable. Build macro: RPRELU_PARAM_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PARA_WIDTH
`define PARA_WIDTH 16
`endif

module rprelu_param_ctrl
    import rprelu_ctrl_pkg::*;
#(
    parameter int CHANNEL_NUM = 512,
    parameter int PARA_WIDTH  = `PARA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_start,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic signed [PARA_WIDTH-1:0] cfg_data,
    input  logic                         run_stop,
    input  logic                         data_e_in,
    output logic                         data_e_dp,
    output logic                         mode,
    output logic signed [PARA_WIDTH-1:0] rprelu_beta  [CHANNEL_NUM],
    output logic signed [PARA_WIDTH-1:0] rprelu_gamma [CHANNEL_NUM],
    output logic signed [PARA_WIDTH-1:0] rprelu_zeta  [CHANNEL_NUM],
    output logic                         busy,
    output logic                         params_valid,
    output logic                         cfg_err
);

    localparam int               IDX_W      = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(CHANNEL_NUM - 1);

    ctrl_state_e              state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [C_DRAIN_CNT_W-1:0] drain_q, drain_d;
    logic                     pv_q, pv_d;
    logic                     in_load;
    logic                     accept;
`ifdef RPRELU_PARAM_CHECKSUM_EN
    logic signed [PARA_WIDTH-1:0] chk_q, chk_d;
    logic                         err_q, err_d;
`endif

    assign in_load = (state_q == ST_LOAD_BETA) || (state_q == ST_LOAD_GAMMA) ||
                     (state_q == ST_LOAD_ZETA) || (state_q == ST_LOAD_CHK);
    assign accept  = cfg_valid && in_load;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        pv_d    = pv_q;
`ifdef RPRELU_PARAM_CHECKSUM_EN
        chk_d   = chk_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD_BETA;
                    idx_d   = '0;
                    pv_d    = 1'b0;
`ifdef RPRELU_PARAM_CHECKSUM_EN
                    chk_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            ST_LOAD_BETA, ST_LOAD_GAMMA, ST_LOAD_ZETA: begin
                if (accept) begin
`ifdef RPRELU_PARAM_CHECKSUM_EN
                    chk_d = chk_q ^ cfg_data;
`endif
                    if (idx_q == C_IDX_LAST) begin
                        idx_d = '0;
                        case (state_q)
                            ST_LOAD_BETA:  state_d = ST_LOAD_GAMMA;
                            ST_LOAD_GAMMA: state_d = ST_LOAD_ZETA;
                            default: begin
`ifdef RPRELU_PARAM_CHECKSUM_EN
                                state_d = ST_LOAD_CHK;
`else
                                state_d = ST_RUN;
                                pv_d    = 1'b1;
`endif
                            end
                        endcase
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_LOAD_CHK: begin
`ifdef RPRELU_PARAM_CHECKSUM_EN
                if (accept) begin
                    if (cfg_data == chk_q) begin
                        state_d = ST_RUN;
                        pv_d    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        pv_d    = 1'b0;
                        err_d   = 1'b1;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RUN: begin
                if (run_stop) begin
                    state_d = ST_DRAIN;
                    drain_d = C_DRAIN_CNT_W'(C_DRAIN_LAT - 1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            drain_q <= '0;
            pv_q    <= 1'b0;
`ifdef RPRELU_PARAM_CHECKSUM_EN
            chk_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            pv_q    <= pv_d;
`ifdef RPRELU_PARAM_CHECKSUM_EN
            chk_q   <= chk_d;
            err_q   <= err_d;
`endif
        end
    end

    // Enable passes through combinationally so a stop cycle's data is not lost.
    assign data_e_dp    = (state_q == ST_RUN) && data_e_in;
    assign mode         = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) ? C_MODE_CALCULATE
                                                                         : C_MODE_CONFIG;
    assign cfg_ready    = in_load;
    assign busy         = in_load || (state_q == ST_DRAIN);
    assign params_valid = pv_q;
`ifdef RPRELU_PARAM_CHECKSUM_EN
    assign cfg_err      = err_q;
`else
    assign cfg_err      = 1'b0;
`endif

    rprelu_param_bank #(.DEPTH(CHANNEL_NUM), .WIDTH(PARA_WIDTH), .IDX_W(IDX_W)) u_bank_beta (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (accept && (state_q == ST_LOAD_BETA)),
        .idx_i   (idx_q),
        .wdata_i (cfg_data),
        .mem_o   (rprelu_beta)
    );

    rprelu_param_bank #(.DEPTH(CHANNEL_NUM), .WIDTH(PARA_WIDTH), .IDX_W(IDX_W)) u_bank_gamma (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (accept && (state_q == ST_LOAD_GAMMA)),
        .idx_i   (idx_q),
        .wdata_i (cfg_data),
        .mem_o   (rprelu_gamma)
    );

    rprelu_param_bank #(.DEPTH(CHANNEL_NUM), .WIDTH(PARA_WIDTH), .IDX_W(IDX_W)) u_bank_zeta (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (accept && (state_q == ST_LOAD_ZETA)),
        .idx_i   (idx_q),
        .wdata_i (cfg_data),
        .mem_o   (rprelu_zeta)
    );

endmodule

`default_nettype wire

// File: tb/tb_rprelu_param_ctrl.sv
// ============================================================================
// Module   : tb_rprelu_param_ctrl
// Brief    : Randomized self-checking bench for rprelu_param_ctrl (CHANNEL_NUM=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rprelu_param_ctrl;
    import rprelu_ctrl_pkg::*;

    localparam int CH = 4;
    localparam int W  = 16;
    localparam int NW = 3 * CH;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cfg_start = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                run_stop = 1'b0;
    logic                data_e_in = 1'b0;
    logic signed [W-1:0] cfg_data = '0;
    logic                cfg_ready, data_e_dp, mode, busy, params_valid, cfg_err;
    logic signed [W-1:0] beta  [CH];
    logic signed [W-1:0] gamma [CH];
    logic signed [W-1:0] zeta  [CH];

    logic signed [W-1:0] exp_bank [3][CH];
    logic signed [W-1:0] wq [$];
    int                  n_checks = 0;
    int                  n_pass = 0;

    always #5 clk = ~clk;

    rprelu_param_ctrl #(.CHANNEL_NUM(CH), .PARA_WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_data     (cfg_data),
        .run_stop     (run_stop),
        .data_e_in    (data_e_in),
        .data_e_dp    (data_e_dp),
        .mode         (mode),
        .rprelu_beta  (beta),
        .rprelu_gamma (gamma),
        .rprelu_zeta  (zeta),
        .busy         (busy),
        .params_valid (params_valid),
        .cfg_err      (cfg_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < CH; i++) exp_bank[b][i] = '0;
    endtask

    task automatic check_banks(input string tag);
        for (int i = 0; i < CH; i++) begin
            check({tag, "_beta"},  beta[i],  exp_bank[0][i]);
            check({tag, "_gamma"}, gamma[i], exp_bank[1][i]);
            check({tag, "_zeta"},  zeta[i],  exp_bank[2][i]);
        end
    endtask

    task automatic check_idle(input string tag, input logic pv, input logic err);
        data_e_in = 1'b1;
        #1;
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_ready"}, cfg_ready, 1'b0);
        check({tag, "_mode"},  mode, C_MODE_CONFIG);
        check({tag, "_dp"},    data_e_dp, 1'b0);
        check({tag, "_pv"},    params_valid, pv);
        check({tag, "_err"},   cfg_err, err);
        data_e_in = 1'b0;
    endtask

    // Builds the stream: 12 parameter words, then the checksum when enabled.
    task automatic build_words(input bit sequential, input bit bad_chk);
        logic signed [W-1:0] x;
        x = '0;
        wq.delete();
        for (int k = 0; k < NW; k++) begin
            wq.push_back(sequential ? W'(k + 1) : W'($urandom));
            x = x ^ wq[k];
        end
`ifdef RPRELU_PARAM_CHECKSUM_EN
        wq.push_back(bad_chk ? 16'hFFFF : x);
`else
        if (bad_chk) wq.push_back(x);
`endif
    endtask

    // Streams wq with random valid gaps; optional 5-cycle hold and early stop.
    task automatic load(input int gap_at, input int stop_after);
        int k;
        int cyc;
        bit gap_done;
        k = 0;
        cyc = 0;
        gap_done = 1'b0;
        cfg_start = 1'b1;
        next_cycle();
        cfg_start = 1'b0;
        #1;
        check("start_pv_clear", params_valid, 1'b0);
        check("start_err_clear", cfg_err, 1'b0);
        while (k < wq.size() && k != stop_after && cyc < 500) begin
            if (k == gap_at && !gap_done) begin
                gap_done = 1'b1;
                repeat (5) begin
                    cfg_valid = 1'b0;
                    cfg_data  = W'($urandom);
                    data_e_in = 1'($urandom);
                    #1;
                    check("gap_ready", cfg_ready, 1'b1);
                    check("gap_dp", data_e_dp, 1'b0);
                    next_cycle();
                    cyc++;
                end
                check_banks("gap_hold");
            end
            cfg_valid = ($urandom_range(0, 3) != 0);
            cfg_data  = wq[k];
            data_e_in = 1'($urandom);
            #1;
            check("load_ready", cfg_ready, 1'b1);
            check("load_busy", busy, 1'b1);
            check("load_dp", data_e_dp, 1'b0);
            check("load_mode", mode, C_MODE_CONFIG);
            @(posedge clk);
            if (cfg_valid) begin
                if (k < NW) exp_bank[k / CH][k % CH] = wq[k];
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        cfg_valid = 1'b0;
        data_e_in = 1'b0;
        if (cyc >= 500) check("load_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_run_entry(input string tag);
        #1;
        check({tag, "_pv"}, params_valid, 1'b1);
        check({tag, "_mode"}, mode, C_MODE_CALCULATE);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ready"}, cfg_ready, 1'b0);
        check({tag, "_err"}, cfg_err, 1'b0);
        check_banks(tag);
    endtask

    task automatic run_then_stop(input int n_rand);
        logic pattern [3];
        pattern[0] = 1'b1;
        pattern[1] = 1'b0;
        pattern[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_e_in = pattern[i];
            #1;
            check("run_pattern_dp", data_e_dp, pattern[i]);
            next_cycle();
        end
        cfg_start = 1'b1;
        next_cycle();
        cfg_start = 1'b0;
        #1;
        check("run_ignore_start_mode", mode, C_MODE_CALCULATE);
        check("run_ignore_start_busy", busy, 1'b0);
        for (int i = 0; i < n_rand; i++) begin
            data_e_in = 1'($urandom);
            #1;
            check("run_rand_dp", data_e_dp, data_e_in);
            next_cycle();
        end
        run_stop  = 1'b1;
        data_e_in = 1'b1;
        #1;
        check("stop_cycle_dp", data_e_dp, 1'b1);
        next_cycle();
        run_stop = 1'b0;
        for (int i = 0; i < C_DRAIN_LAT; i++) begin
            data_e_in = 1'b1;
            #1;
            check("drain_busy", busy, 1'b1);
            check("drain_mode", mode, C_MODE_CALCULATE);
            check("drain_dp", data_e_dp, 1'b0);
            next_cycle();
        end
        check_idle("after_drain", 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_model();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_banks("reset");
        check_idle("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        next_cycle();
        check_idle("pre_load", 1'b0, 1'b0);

        build_words(1'b1, 1'b0);
        load(6, -1);
        check_run_entry("seq_load");
        run_then_stop(8);

        next_cycle();
        build_words(1'b0, 1'b0);
        load(-1, -1);
        check_run_entry("rand_load");
        run_then_stop(4);

        next_cycle();
        build_words(1'b0, 1'b0);
        load(-1, 6);
        rst_n = 1'b0;
        clear_model();
        #1;
        check_banks("mid_reset");
        check_idle("mid_reset", 1'b0, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        build_words(1'b0, 1'b0);
        load(9, -1);
        check_run_entry("post_reset_load");
        run_then_stop(3);

`ifdef RPRELU_PARAM_CHECKSUM_EN
        next_cycle();
        build_words(1'b1, 1'b1);
        load(-1, -1);
        #1;
        check_banks("bad_chk");
        check_idle("bad_chk", 1'b0, 1'b1);
        next_cycle();
        build_words(1'b0, 1'b0);
        load(-1, -1);
        check_run_entry("after_bad_chk");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
